sha3_scan_result_collector: RTL and testbench

- Host-side partner of the SHA3 scanner instantiator: accepts a scan job (threshold plus 24-word blob) from the host command path.
- Drives the scanner's start, threshold and blobby inputs, and tracks the scanner through dispatching and evaluating until the scan completes.
- Captures every found result (nonce, hash) into a small FIFO that the host drains through a valid/ready port.
- Sits between the AXI register/DMA front end and the scanner instantiator.

---
 rtl/sha3_scan_pkg.sv | 29 ++
 rtl/sha3_result_fifo.sv | 74 +++++++
 rtl/sha3_scan_result_collector.sv | 159 +++++++++++++++
 tb/tb_sha3_scan_result_collector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_scan_pkg.sv
// Shared types for the SHA3 scan result collector: job/result payloads and the
// collector FSM state encoding.
package sha3_scan_pkg;

  localparam int BLOB_WORDS = 24;
  localparam int HASH_WORDS = 50;

  typedef logic [HASH_WORDS-1:0][31:0] hash_t;
  typedef logic [BLOB_WORDS-1:0][31:0] blob_t;

  typedef struct packed {
    logic [31:0] nonce;
    hash_t       hash;
  } scan_result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DONE
  } collector_state_e;

  // Results are only meaningful once the scanner has been started.
  function automatic logic captures_found(collector_state_e s);
    return (s == ST_WAIT_BUSY) || (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/sha3_result_fifo.sv
// First-word-fall-through FIFO of scan results. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sha3_result_fifo
  import sha3_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  scan_result_t push_data,
  input  logic         pop,
  output scan_result_t pop_data,
  output logic         empty,
  output logic         accepted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  scan_result_t     mem_q [DEPTH];

  logic full;
  logic do_pop;
  logic do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign accepted = do_push;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates visibility, so
  // stale entries are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sha3_scan_result_collector.sv
// Host-side collector: launches one scan job on the SHA3 scanner, follows it to
// completion and buffers every found (nonce, hash) for the host to drain.
module sha3_scan_result_collector
  import sha3_scan_pkg::*;
#(
  parameter int RES_DEPTH     = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_threshold,
  input  logic [BLOB_WORDS-1:0][31:0]  cmd_blobby,
  output logic                         scan_start,
  output logic [63:0]                  scan_threshold,
  output logic [BLOB_WORDS-1:0][31:0]  scan_blobby,
  input  logic                         scan_ready,
  input  logic                         scan_dispatching,
  input  logic                         scan_evaluating,
  input  logic                         scan_found,
  input  logic [HASH_WORDS-1:0][31:0]  scan_hash,
  input  logic [31:0]                  scan_nonce,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_nonce,
  output logic [HASH_WORDS-1:0][31:0]  res_hash,
  output logic                         busy,
  output logic [31:0]                  scans_done,
  output logic [15:0]                  results_dropped,
  output logic [7:0]                   start_timeouts
);

  localparam int WAIT_W      = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int WAIT_LAST_I = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  collector_state_e state_q, state_d;

  logic [63:0]       threshold_q, threshold_d;
  blob_t             blobby_q, blobby_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       scans_done_q, scans_done_d;
  logic [15:0]       dropped_q, dropped_d;
  logic [7:0]        timeouts_q, timeouts_d;

  logic         cmd_fire;
  logic         scan_active;
  logic         timeout_hit;
  logic         capture;
  logic         fifo_empty;
  logic         fifo_accepted;
  scan_result_t push_res;
  scan_result_t head_res;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign scan_active = scan_dispatching || scan_evaluating;
  assign timeout_hit = (START_TIMEOUT != 0) && (state_q == ST_WAIT_BUSY) &&
                       !scan_active && (wait_cnt_q == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cmd_fire) state_d = ST_LAUNCH;
      ST_LAUNCH:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (scan_active)      state_d = ST_RUN;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_RUN:       if (!scan_active) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything here decodes the registered state.
  always_comb begin
    cmd_ready  = 1'b0;
    scan_start = 1'b0;
    busy       = (state_q != ST_IDLE);
    capture    = scan_found && captures_found(state_q);
    case (state_q)
      ST_IDLE:   cmd_ready  = scan_ready;
      ST_LAUNCH: scan_start = 1'b1;
      default:   ;
    endcase
  end

  // Job registers and statistics.
  always_comb begin
    threshold_d  = threshold_q;
    blobby_d     = blobby_q;
    wait_cnt_d   = '0;
    scans_done_d = scans_done_q;
    dropped_d    = dropped_q;
    timeouts_d   = timeouts_q;

    if (cmd_fire) begin
      threshold_d = cmd_threshold;
      blobby_d    = cmd_blobby;
    end
    if (state_q == ST_WAIT_BUSY && !timeout_hit) wait_cnt_d = wait_cnt_q + WAIT_ONE;
    if (state_q == ST_DONE) scans_done_d = scans_done_q + 32'd1;
    if (timeout_hit && timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
    if (capture && !fifo_accepted && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold_q  <= '0;
      blobby_q     <= '0;
      wait_cnt_q   <= '0;
      scans_done_q <= '0;
      dropped_q    <= '0;
      timeouts_q   <= '0;
    end else begin
      threshold_q  <= threshold_d;
      blobby_q     <= blobby_d;
      wait_cnt_q   <= wait_cnt_d;
      scans_done_q <= scans_done_d;
      dropped_q    <= dropped_d;
      timeouts_q   <= timeouts_d;
    end
  end

  assign push_res.nonce = scan_nonce;
  assign push_res.hash  = scan_hash;

  sha3_result_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_res),
    .pop       (res_ready),
    .pop_data  (head_res),
    .empty     (fifo_empty),
    .accepted  (fifo_accepted)
  );

  assign res_valid       = !fifo_empty;
  assign res_nonce       = head_res.nonce;
  assign res_hash        = head_res.hash;
  assign scan_threshold  = threshold_q;
  assign scan_blobby     = blobby_q;
  assign scans_done      = scans_done_q;
  assign results_dropped = dropped_q;
  assign start_timeouts  = timeouts_q;

endmodule

// File: tb/tb_sha3_scan_result_collector.sv
// Directed bench for the scan result collector: a per-cycle vector table for a
// full scan, then hand sequences for FIFO overflow, start timeout and reset.
module tb_sha3_scan_result_collector;
  import sha3_scan_pkg::*;

  localparam int RES_DEPTH     = 4;
  localparam int START_TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_threshold;
  blob_t       cmd_blobby;
  logic        scan_start;
  logic [63:0] scan_threshold;
  blob_t       scan_blobby;
  logic        scan_ready;
  logic        scan_dispatching;
  logic        scan_evaluating;
  logic        scan_found;
  hash_t       scan_hash;
  logic [31:0] scan_nonce;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  hash_t       res_hash;
  logic        busy;
  logic [31:0] scans_done;
  logic [15:0] results_dropped;
  logic [7:0]  start_timeouts;

  sha3_scan_result_collector #(
    .RES_DEPTH     (RES_DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_threshold    (cmd_threshold),
    .cmd_blobby       (cmd_blobby),
    .scan_start       (scan_start),
    .scan_threshold   (scan_threshold),
    .scan_blobby      (scan_blobby),
    .scan_ready       (scan_ready),
    .scan_dispatching (scan_dispatching),
    .scan_evaluating  (scan_evaluating),
    .scan_found       (scan_found),
    .scan_hash        (scan_hash),
    .scan_nonce       (scan_nonce),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_nonce        (res_nonce),
    .res_hash         (res_hash),
    .busy             (busy),
    .scans_done       (scans_done),
    .results_dropped  (results_dropped),
    .start_timeouts   (start_timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cv;
    logic        sr;
    logic        d;
    logic        e;
    logic        f;
    logic [31:0] nonce;
    logic        rr;
  } stim_t;

  typedef struct {
    logic        cr;
    logic        st;
    logic        bz;
    logic        rv;
    logic [31:0] rn;
    logic [31:0] sd;
    logic [15:0] dr;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  x;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  // Each word of a found hash is derived from its nonce so payload mix-ups show.
  function automatic hash_t make_hash(logic [31:0] n);
    hash_t h;
    for (int i = 0; i < HASH_WORDS; i++) h[i] = n + 32'(i) * 32'h0101_0000;
    return h;
  endfunction

  assign scan_hash = make_hash(scan_nonce);

  function automatic stim_t stim(logic cv, logic sr, logic d, logic e, logic f,
                                 logic [31:0] nonce, logic rr);
    stim_t s;
    s.rst = 1'b0; s.cv = cv; s.sr = sr; s.d = d; s.e = e; s.f = f;
    s.nonce = nonce; s.rr = rr;
    return s;
  endfunction

  function automatic exp_t ex(logic cr, logic st, logic bz, logic rv,
                              logic [31:0] rn, logic [31:0] sd, logic [15:0] dr);
    exp_t x;
    x.cr = cr; x.st = st; x.bz = bz; x.rv = rv; x.rn = rn; x.sd = sd; x.dr = dr;
    return x;
  endfunction

  task automatic add(stim_t s, exp_t x);
    vec_t v;
    v.s = s;
    v.x = x;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1ns later.
  task automatic apply(stim_t s);
    @(negedge clk);
    rst              = s.rst;
    cmd_valid        = s.cv;
    scan_ready       = s.sr;
    scan_dispatching = s.d;
    scan_evaluating  = s.e;
    scan_found       = s.f;
    scan_nonce       = s.nonce;
    res_ready        = s.rr;
    #1;
  endtask

  task automatic set_job(logic [63:0] thr, int step);
    cmd_threshold = thr;
    for (int i = 0; i < BLOB_WORDS; i++) cmd_blobby[i] = 32'(i * step);
  endtask

  task automatic check_head(string name, logic [31:0] n);
    hash_t h;
    h = make_hash(n);
    check({name, " res_valid"}, 64'(res_valid), 64'd1);
    check({name, " res_nonce"}, 64'(res_nonce), 64'(n));
    check({name, " res_hash[0]"}, 64'(res_hash[0]), 64'(h[0]));
    check({name, " res_hash[49]"}, 64'(res_hash[49]), 64'(h[49]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t rs;
    logic [31:0] drain [4];
    int busy_cycles;
    bit ended;
    hash_t eh;

    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    scan_ready = 1'b0;
    scan_dispatching = 1'b0;
    scan_evaluating = 1'b0;
    scan_found = 1'b0;
    scan_nonce = '0;
    res_ready = 1'b0;
    set_job(64'h0000_00FF_FFFF_FFFF, 1);

    // One full scan, one row per cycle: handshake, launch, 10 dispatching,
    // 5 evaluating, done, then the host drains three results.
    add(stim(1, 1, 0, 0, 1, 32'hDEAD, 0), ex(1, 0, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0, 1, 32'hDEAD, 0), ex(0, 1, 1, 0, 0, 0, 0));
    for (int c = 0; c < 10; c++) begin
      case (c)
        3:       add(stim(0, 0, 1, 0, 1, 32'h10, 0), ex(0, 0, 1, 0, 0, 0, 0));
        5:       add(stim(0, 0, 1, 0, 1, 32'h20, 0), ex(0, 0, 1, 1, 32'h10, 0, 0));
        7:       add(stim(0, 0, 1, 0, 1, 32'h30, 0), ex(0, 0, 1, 1, 32'h10, 0, 0));
        default: add(stim(0, 0, 1, 0, 0, 0, 0), ex(0, 0, 1, (c > 3), 32'h10, 0, 0));
      endcase
    end
    for (int c = 0; c < 5; c++)
      add(stim(0, 0, 0, 1, 0, 0, 0), ex(0, 0, 1, 1, 32'h10, 0, 0));
    add(stim(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 1, 1, 32'h10, 0, 0));
    add(stim(0, 1, 0, 0, 0, 0, 0), ex(0, 0, 1, 1, 32'h10, 0, 0));
    add(stim(0, 1, 0, 0, 0, 0, 1), ex(1, 0, 0, 1, 32'h10, 1, 0));
    add(stim(0, 1, 0, 0, 0, 0, 1), ex(1, 0, 0, 1, 32'h20, 1, 0));
    add(stim(0, 1, 0, 0, 0, 0, 1), ex(1, 0, 0, 1, 32'h30, 1, 0));
    add(stim(0, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 1, 0));

    // Reset state.
    rs = stim(0, 0, 0, 0, 0, 0, 0);
    rs.rst = 1'b1;
    apply(rs);
    apply(rs);
    check("reset busy", 64'(busy), 64'd0);
    check("reset scan_start", 64'(scan_start), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset scans_done", 64'(scans_done), 64'd0);
    check("reset results_dropped", 64'(results_dropped), 64'd0);
    check("reset start_timeouts", 64'(start_timeouts), 64'd0);
    check("reset scan_threshold", scan_threshold, 64'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].s);
      check($sformatf("row%0d cmd_ready", i), 64'(cmd_ready), 64'(vecs[i].x.cr));
      check($sformatf("row%0d scan_start", i), 64'(scan_start), 64'(vecs[i].x.st));
      check($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].x.bz));
      check($sformatf("row%0d res_valid", i), 64'(res_valid), 64'(vecs[i].x.rv));
      if (vecs[i].x.rv) begin
        eh = make_hash(vecs[i].x.rn);
        check($sformatf("row%0d res_nonce", i), 64'(res_nonce), 64'(vecs[i].x.rn));
        check($sformatf("row%0d res_hash[0]", i), 64'(res_hash[0]), 64'(eh[0]));
      end
      check($sformatf("row%0d scans_done", i), 64'(scans_done), 64'(vecs[i].x.sd));
      check($sformatf("row%0d results_dropped", i), 64'(results_dropped), 64'(vecs[i].x.dr));
    end
    check("job A scan_threshold", scan_threshold, 64'h0000_00FF_FFFF_FFFF);
    check("job A scan_blobby[23]", 64'(scan_blobby[23]), 64'd23);
    check("job A scan_blobby[5]", 64'(scan_blobby[5]), 64'd5);

    // Overflow: six founds into a four-entry FIFO, then a push while full
    // that coincides with a pop.
    set_job(64'hDEAD_BEEF_0000_0001, 3);
    apply(stim(1, 1, 0, 0, 0, 0, 0));
    check("ovf handshake cmd_ready", 64'(cmd_ready), 64'd1);
    apply(stim(0, 0, 0, 0, 0, 0, 0));
    check("ovf scan_start", 64'(scan_start), 64'd1);
    check("ovf scan_blobby[23]", 64'(scan_blobby[23]), 64'd69);
    apply(stim(0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) apply(stim(0, 0, 1, 0, 1, 32'h100 + 32'(k), 0));
    apply(stim(0, 0, 1, 0, 0, 0, 0));
    check("ovf results_dropped", 64'(results_dropped), 64'd2);
    check_head("ovf full head", 32'h100);
    apply(stim(0, 0, 1, 0, 1, 32'h106, 1));
    check_head("ovf push+pop head", 32'h100);
    drain[0] = 32'h101; drain[1] = 32'h102; drain[2] = 32'h103; drain[3] = 32'h106;
    for (int k = 0; k < 4; k++) begin
      apply(stim(0, 0, 1, 0, 0, 0, 1));
      check_head($sformatf("ovf drain%0d", k), drain[k]);
    end
    check("ovf no drop on push+pop", 64'(results_dropped), 64'd2);
    apply(stim(0, 0, 1, 0, 0, 0, 0));
    check("ovf drained res_valid", 64'(res_valid), 64'd0);
    apply(stim(0, 1, 0, 0, 0, 0, 0));
    apply(stim(0, 1, 0, 0, 0, 0, 0));
    check("ovf DONE cmd_ready", 64'(cmd_ready), 64'd0);
    check("ovf DONE busy", 64'(busy), 64'd1);
    apply(stim(0, 1, 0, 0, 0, 0, 0));
    check("ovf idle busy", 64'(busy), 64'd0);
    check("ovf scans_done", 64'(scans_done), 64'd2);

    // Start timeout: the scanner never goes busy.
    set_job(64'd1, 1);
    apply(stim(1, 1, 0, 0, 0, 0, 0));
    busy_cycles = 0;
    ended = 1'b0;
    for (int c = 0; c < 600 && !ended; c++) begin
      apply(stim(0, 0, 0, 0, 0, 0, 0));
      if (busy) busy_cycles++;
      else ended = 1'b1;
    end
    check("timeout busy cycles (launch + wait)", 64'(busy_cycles), 64'd256);
    check("timeout start_timeouts", 64'(start_timeouts), 64'd1);
    check("timeout scans_done", 64'(scans_done), 64'd2);

    // Reset mid-run with two results buffered.
    set_job(64'h5555, 7);
    apply(stim(1, 1, 0, 0, 0, 0, 0));
    apply(stim(0, 0, 0, 0, 0, 0, 0));
    apply(stim(0, 0, 1, 0, 0, 0, 0));
    apply(stim(0, 0, 1, 0, 1, 32'h200, 0));
    apply(stim(0, 0, 1, 0, 1, 32'h201, 0));
    apply(stim(0, 0, 1, 0, 0, 0, 0));
    check_head("rst pre head", 32'h200);
    check("rst pre busy", 64'(busy), 64'd1);
    rs = stim(0, 0, 1, 0, 0, 0, 0);
    rs.rst = 1'b1;
    apply(rs);
    apply(stim(0, 1, 1, 0, 1, 32'h300, 0));
    check("rst busy", 64'(busy), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst scan_start", 64'(scan_start), 64'd0);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst scans_done", 64'(scans_done), 64'd0);
    check("rst results_dropped", 64'(results_dropped), 64'd0);
    check("rst start_timeouts", 64'(start_timeouts), 64'd0);
    check("rst scan_threshold", scan_threshold, 64'd0);
    check("rst scan_blobby[23]", 64'(scan_blobby[23]), 64'd0);
    for (int c = 0; c < 4; c++) begin
      apply(stim(0, 1, 1, 0, 0, 0, 0));
      check($sformatf("post-rst%0d scan_start", c), 64'(scan_start), 64'd0);
      check($sformatf("post-rst%0d res_valid", c), 64'(res_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
